// File: rtl/add_result_buffer.sv
// ============================================================================
// Module   : add_result_buffer
// Function : Credit-tracked result FIFO behind the non-stalling 32-bit adder.
//            Optional macro ADD_RESULT_SAT_EN stores carry-out results
//            saturated to all ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module add_result_buffer #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         i_issue_valid,
  output logic                         o_issue_ok,
  input  logic                         i_res_valid,
  input  logic [WIDTH-1:0]             i_res_sum,
  input  logic                         i_res_cout,
  output logic                         o_m_valid,
  input  logic                         i_m_ready,
  output logic [WIDTH-1:0]             o_m_sum,
  output logic                         o_m_cout,
  output logic [$clog2(DEPTH+1)-1:0]   o_level,
  output logic                         o_err
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH:0]       r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_wptr;
  logic [c_PTR_W-1:0]   r_rptr;
  logic [c_LVL_W-1:0]   r_level;
  logic [c_LVL_W-1:0]   r_inflight;
  logic                 r_err;

  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_issue_acc;
  logic                 w_dec;
  logic [c_LVL_W:0]     w_credits;
  logic [WIDTH:0]       w_entry;
  logic [WIDTH:0]       w_head;

  assign w_full      = (r_level == c_LVL_W'(DEPTH));
  assign o_m_valid   = (r_level != '0);
  assign w_pop       = o_m_valid & i_m_ready;
  // A full buffer still accepts a result when the head leaves in the same cycle.
  assign w_push      = i_res_valid & (~w_full | w_pop);
  assign w_credits   = {1'b0, r_level} + {1'b0, r_inflight};
  assign o_issue_ok  = (w_credits < (c_LVL_W + 1)'(DEPTH));
  assign w_issue_acc = i_issue_valid & o_issue_ok;
  assign w_dec       = i_res_valid & (r_inflight != '0);

`ifdef ADD_RESULT_SAT_EN
  assign w_entry = i_res_cout ? {1'b1, {WIDTH{1'b1}}} : {1'b0, i_res_sum};
`else
  assign w_entry = {i_res_cout, i_res_sum};
`endif

  assign w_head   = r_mem[r_rptr];
  assign o_m_sum  = o_m_valid ? w_head[WIDTH-1:0] : '0;
  assign o_m_cout = o_m_valid ? w_head[WIDTH] : 1'b0;
  assign o_level  = r_level;
  assign o_err    = r_err;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_level    <= '0;
      r_inflight <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + c_PTR_W'(1);

      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase

      case ({w_issue_acc, w_dec})
        2'b10:   r_inflight <= r_inflight + c_LVL_W'(1);
        2'b01:   r_inflight <= r_inflight - c_LVL_W'(1);
        default: r_inflight <= r_inflight;
      endcase

      if ((i_issue_valid & ~o_issue_ok) |
          (i_res_valid & w_full & ~w_pop) |
          (i_res_valid & (r_inflight == '0))) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
